// File: rtl/instr_sequencer.sv
// instr_sequencer: PC/fetch/issue controller for the control FSM, HALT/JMP handled locally; SEQ_SINGLE_STEP_EN adds step_mode/step and a PAUSE state
module instr_sequencer #(
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [11:0]   imem_data,
  output logic [11:0]   instr_o,
  output logic          w_o,
  input  logic          done_i,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] retired
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] ISSUE  = 3'd3;
  localparam logic [2:0] EXEC   = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;
`ifdef SEQ_SINGLE_STEP_EN
  localparam logic [2:0] PAUSE  = 3'd6;
`endif
  logic [2:0] state;
  logic [3:0] op;
  assign op        = imem_data[11:8];
  assign imem_rd   = state == FETCH;
  assign w_o       = state == ISSUE;
  assign imem_addr = pc;
  assign halted    = state == HALTED;
  assign busy      = state != IDLE && state != HALTED;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      instr_o <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE, HALTED: if (start) begin
          pc    <= '0;
          state <= FETCH;
        end
        FETCH: state <= WAIT;
        WAIT: if (op == 4'h0) state <= HALTED;
        else if (op == 4'hF) begin
          pc    <= AW'(imem_data[7:0]);
          state <= FETCH;
        end else begin
          instr_o <= imem_data;
          pc      <= pc + 1'b1;
          state   <= ISSUE;
        end
        ISSUE: state <= EXEC;
        EXEC: if (done_i) begin
          if (~&retired) retired <= retired + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
          state <= step_mode ? PAUSE : FETCH;
`else
          state <= FETCH;
`endif
        end
`ifdef SEQ_SINGLE_STEP_EN
        PAUSE: if (step || !step_mode) state <= FETCH;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: program vectors, issue scoreboard and multi-cycle corner sequences for instr_sequencer
module tb_instr_sequencer;
  localparam int AW = 8, CW = 16;
  logic clk = 0, rst = 1, start = 0, resp_done = 0, man_done = 0, done_i;
  logic imem_rd, w_o, busy, halted;
  logic [AW-1:0] imem_addr, pc;
  logic [11:0] imem_data = '0, instr_o, e;
  logic [CW-1:0] retired;
  logic [11:0] mem [256];
  logic [11:0] exp_q [$];
  int checks = 0, passes = 0, dly = 0, cnt = -1, exp_ret = 0;
`ifdef SEQ_SINGLE_STEP_EN
  logic step_mode = 0, step = 0;
`endif
  typedef struct {
    logic [11:0]   img [8];
    logic [11:0]   iss [4];
    int            n;
    logic [AW-1:0] fpc;
  } vec_t;
  vec_t tv [6];

  assign done_i = resp_done | man_done;

  instr_sequencer #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_o(instr_o), .w_o(w_o), .done_i(done_i), .pc(pc),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  // done responder (pulse dly+1 cycles after w_o) and issue scoreboard
  always @(negedge clk) begin
    resp_done = (cnt == 0);
    if (cnt >= 0) cnt--;
    if (rst) cnt = -1;
    else if (w_o) begin
      cnt = dly;
      checks++;
      if (exp_q.size() == 0) $display("FAIL issue_unexpected: got instr %h, expected no issue", instr_o);
      else begin
        e = exp_q.pop_front();
        if (instr_o === e) passes++;
        else $display("FAIL issue_instr: got %h expected %h", instr_o, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 1000 && !halted; i++) @(negedge clk);
    chk("halt_reached", halted, 1);
  endtask

  task automatic wait_wo();
    for (int i = 0; i < 100 && !w_o; i++) @(negedge clk);
    chk("wo_seen", w_o, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic load(input logic [11:0] a, input logic [11:0] b);
    foreach (mem[i]) mem[i] = '0;
    mem[0] = a;
    mem[1] = b;
  endtask

  task automatic run_vec(input vec_t v);
    foreach (mem[i]) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = v.img[i];
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.iss[i]);
    pulse_start();
    chk("fetch_rd", imem_rd, 1);
    chk("fetch_addr", imem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    if (v.img[0][11:8] != 4'h0 && v.img[0][11:8] != 4'hF) chk("issue_latency", w_o, 1);
    wait_halt();
    exp_ret += v.n;
    chk("final_pc", pc, v.fpc);
    chk("retired", retired, exp_ret);
    chk("busy_halted", busy, 0);
    chk("all_issued", exp_q.size(), 0);
  endtask

  initial begin
    logic ok;
    tv[0] = '{img: '{12'h110, 12'h212, 12'h000, 0, 0, 0, 0, 0}, iss: '{12'h110, 12'h212, 0, 0}, n: 2, fpc: 8'd2};
    tv[1] = '{img: '{12'hF05, 0, 0, 0, 0, 12'h312, 12'h000, 0}, iss: '{12'h312, 0, 0, 0}, n: 1, fpc: 8'd6};
    tv[2] = '{img: '{12'hF03, 12'h000, 0, 12'h523, 12'hF01, 0, 0, 0}, iss: '{12'h523, 0, 0, 0}, n: 1, fpc: 8'd1};
    tv[3] = '{img: '{12'h000, 12'h110, 0, 0, 0, 0, 0, 0}, iss: '{0, 0, 0, 0}, n: 0, fpc: 8'd0};
    tv[4] = '{img: '{12'hA01, 12'hB02, 12'hC03, 12'hE04, 12'h000, 0, 0, 0}, iss: '{12'hA01, 12'hB02, 12'hC03, 12'hE04}, n: 4, fpc: 8'd4};
    tv[5] = '{img: '{12'h7AB, 12'hF06, 12'h999, 0, 0, 0, 12'h000, 0}, iss: '{12'h7AB, 0, 0, 0}, n: 1, fpc: 8'd6};
    foreach (mem[i]) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_w_o", w_o, 0);
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_retired", retired, 0);
    rst = 0;
    foreach (tv[k]) run_vec(tv[k]);
    // stall in EXEC, plus done_i held high through FETCH/WAIT/ISSUE
    load(12'h110, 12'h000);
    exp_q.push_back(12'h110);
    dly = 10;
    @(negedge clk) start = 1;
    @(negedge clk) begin start = 0; man_done = 1; end
    @(negedge clk);
    @(negedge clk);
    chk("stall_issue", w_o, 1);
    @(negedge clk) man_done = 0;
    ok = 1;
    for (int i = 0; i < 9; i++) begin
      ok &= !w_o && instr_o == 12'h110 && busy && retired == CW'(exp_ret);
      @(negedge clk);
    end
    chk("stall_stable", ok, 1);
    wait_halt();
    exp_ret++;
    chk("stall_retired", retired, exp_ret);
    dly = 0;
    // pc wrap from 8'hFF to 0, then restart from HALTED with start pulses while busy
    load(12'hFFF, 12'h000);
    mem[255] = 12'h410;
    exp_q.push_back(12'h410);
    pulse_start();
    wait_wo();
    mem[0] = 12'h000;
    wait_halt();
    exp_ret++;
    chk("wrap_pc", pc, 0);
    chk("wrap_retired", retired, exp_ret);
    mem[0] = 12'h520;
    exp_q.push_back(12'h520);
    pulse_start();
    wait_wo();
    start = 1;
    @(negedge clk) start = 0;
    wait_halt();
    exp_ret++;
    chk("restart_pc", pc, 1);
    chk("restart_retired", retired, exp_ret);
    chk("restart_issued", exp_q.size(), 0);
`ifdef SEQ_SINGLE_STEP_EN
    load(12'h110, 12'h120);
    exp_q.push_back(12'h110);
    exp_q.push_back(12'h120);
    step_mode = 1;
    step = 1;
    pulse_start();
    step = 0;
    wait_wo();
    @(negedge clk);
    @(negedge clk);
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      ok &= !imem_rd && !w_o && busy;
      @(negedge clk);
    end
    chk("pause_hold", ok, 1);
    chk("pause_retired", retired, exp_ret + 1);
    step = 1;
    @(negedge clk) step = 0;
    wait_wo();
    chk("step_instr", instr_o, 12'h120);
    repeat (3) @(negedge clk);
    chk("pause_again", busy && !imem_rd, 1);
    step_mode = 0;
    wait_halt();
    exp_ret += 2;
    chk("step_retired", retired, exp_ret);
`endif
    // reset in EXEC, then reset while w_o is high
    load(12'h130, 12'h000);
    exp_q.push_back(12'h130);
    dly = 50;
    pulse_start();
    wait_wo();
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_w_o", w_o, 0);
    chk("mid_rst_rd", imem_rd, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_retired", retired, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_instr", instr_o, 0);
    @(negedge clk) rst = 0;
    exp_ret = 0;
    load(12'h140, 12'h000);
    exp_q.push_back(12'h140);
    pulse_start();
    wait_wo();
    #2 rst = 1;
    #1 chk("async_w_o", w_o, 0);
    @(negedge clk) rst = 0;
    dly = 0;
    run_vec(tv[0]);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Fetch/issue controller for the simple CPU control FSM.
- Keeps a program counter and reads 12-bit instructions from an external synchronous instruction memory.
- Hands each instruction to the control FSM through its instruction/w inputs and waits for the FSM's completion pulse.
- Handles HALT and JMP itself, so the control FSM only sees datapath operations.

Parameters:
AW, 8, instruction memory address width (PC width)
CW, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin execution at address 0; honoured only in IDLE or HALTED
imem_rd  output  1  instruction memory read strobe, one cycle wide
imem_addr  output  AW  instruction memory address (= pc)
imem_data  input  12  instruction memory read data, valid the cycle after imem_rd
instr_o  output  12  instruction presented to control FSM instruction_F
w_o  output  1  issue strobe to control FSM w, one cycle per issued instruction
done_i  input  1  control FSM completion pulse
pc  output  AW  current program counter
busy  output  1  high in every state except IDLE and HALTED
halted  output  1  high in HALTED
retired  output  CW  count of instructions completed by the control FSM

Behaviour:
- Instruction format: [11:8] opcode, [7:4] reg x, [3:0] reg y.
- Opcode 4'b0000 is HALT.
- Opcode 4'b1111 is JMP; the target is instr[7:0] truncated or zero-extended to AW.
- All other opcodes are datapath instructions and are issued to the control FSM.

Reset (async, rst=1): state=IDLE, pc=0, instr_o=0, w_o=0, imem_rd=0, busy=0, halted=0, retired=0.

States:
- IDLE: start=1 -> pc<=0, go to FETCH.
- FETCH: imem_rd=1, imem_addr=pc, for exactly one cycle -> WAIT.
- WAIT: imem_data is sampled at the end of this cycle and decoded:
  - HALT -> HALTED; pc unchanged (points at the HALT word).
  - JMP -> pc<=target, go to FETCH. Nothing is issued and retired is unchanged.
  - Otherwise -> instr_o<=imem_data, pc<=pc+1, go to ISSUE.
- ISSUE: w_o=1 for exactly one cycle with instr_o stable -> EXEC.
- EXEC: w_o=0 and instr_o held.
  - done_i=1 -> retired<=retired+1, go to FETCH, or to PAUSE when the optional feature is active.
  - There is no timeout; EXEC waits indefinitely.
- HALTED: halted=1. start=1 -> pc<=0, go to FETCH. retired is not cleared.

Timing and boundary rules:
- Latency: start sampled in cycle N -> imem_rd in N+1 -> w_o in N+3.
  - Minimum instruction period is 4 cycles (FETCH, WAIT, ISSUE, one EXEC cycle with done_i).
- pc+1 wraps modulo 2^AW (e.g. AW=8: pc goes 8'hFF -> 8'h00).
- retired saturates at all-ones and never wraps.
- done_i outside EXEC is ignored.
- start outside IDLE/HALTED is ignored.
- A JMP to its own address loops forever with busy=1 and never retires.
- A done_i arriving in the same cycle as ISSUE is ignored; it is only accepted in EXEC.
- rst asserted in any state returns immediately to reset values. A pending FSM operation is abandoned and w_o deasserts asynchronously.
- imem_addr equals pc in every state.

Optional Feature:
Macro SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds inputs step_mode (1) and step (1), and state PAUSE.
  - With step_mode=1, EXEC+done_i goes to PAUSE instead of FETCH.
  - PAUSE holds (busy=1, no imem_rd, no w_o) until step=1, then goes to FETCH.
  - With step_mode=0, PAUSE is never entered.
  - step outside PAUSE is ignored.
  - Clearing step_mode while in PAUSE releases to FETCH on the next cycle.
- When undefined: neither port nor state exists, and behaviour is exactly as described above.

Test Plan:
1. Reset mid-run: assert rst while in EXEC -> all outputs at reset values in the same cycle; pc=0, retired=0, busy=0.
2. Straight-line program: mem[0]=12'h110, mem[1]=12'h212, mem[2]=12'h000; done_i pulsed 1 cycle after each w_o; start -> w_o pulses with instr_o 12'h110 then 12'h212; then halted=1, pc=2, retired=2, w_o first high 3 cycles after start.
3. Jump: mem[0]=12'hF05, mem[5]=12'h312, mem[6]=12'h000 -> single issue of 12'h312, final pc=6, retired=1, no w_o for the JMP.
4. Stall and spurious done: hold done_i=0 for 10 cycles in EXEC, then pulse -> w_o stays low and instr_o stable throughout; done_i pulsed in FETCH/WAIT is ignored (retired unchanged).
5. Wrap and restart: AW=8, pc=8'hFF holding 12'h410, mem[0]=12'h000 -> pc wraps to 0 and halts; start in HALTED reruns from 0 with retired preserved; start while busy is ignored.
6. SEQ_SINGLE_STEP_EN with step_mode=1: after each done_i the sequencer sits in PAUSE with no imem_rd for 5 cycles; each step pulse yields exactly one further w_o.
